rowptr_streamer: RTL and testbench
==================================

ROWPTR_STREAMER -- requirements
Module: rowptr_streamer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 5, meaning kernel rows per filter; each memory word holds NUM_ROWS+1 cumulative pointers.
REQ-002 SHALL have parameter PTR_W, default 8, meaning width of one pointer field.
REQ-003 SHALL have parameter ADDR_W, default 7, meaning pointer-memory address width.
REQ-004 SHALL have parameter OFS_W, default 16, meaning width of the global nonzero-weight offset.
REQ-005 SHALL have parameter SKIP_EMPTY, default 0, meaning 1 suppresses rows of length 0.
REQ-006 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse that launches a job; ignored unless idle.
REQ-009 SHALL have port base_addr  in  ADDR_W  first memory word of the job.
REQ-010 SHALL have port num_filters  in  ADDR_W  words (filters) in the job, where 0 means an empty job.
REQ-011 SHALL have port mem_en  out  1  memory read enable.
REQ-012 SHALL have port mem_addr  out  ADDR_W  memory read address.
REQ-013 SHALL have port mem_data  in  (NUM_ROWS+1)*PTR_W  read data, valid one cycle after mem_en; ptr[i] occupies bits [(NUM_ROWS-i)*PTR_W +: PTR_W], so ptr[0] is the MSB field.
REQ-014 SHALL have port out_valid  out  1  row descriptor valid.
REQ-015 SHALL have port out_ready  in  1  downstream accepts the descriptor.
REQ-016 SHALL have port out_filter  out  ADDR_W  filter index within the job.
REQ-017 SHALL have port out_row  out  clog2(NUM_ROWS)  row index.
REQ-018 SHALL have port out_start  out  OFS_W  global index of the row's first nonzero weight.
REQ-019 SHALL have port out_len  out  PTR_W  nonzero count in the row.
REQ-020 SHALL have port out_last  out  1  marks the final descriptor of the job.
REQ-021 SHALL have port busy  out  1  a job is in progress.
REQ-022 SHALL have port done  out  1  one-cycle pulse at job completion.
REQ-023 SHALL have port err  out  1  sticky pointer-corruption flag.

Function
REQ-024 SHALL implement FSM states IDLE, FETCH, WAIT, EMIT, FIN.
- IDLE->FETCH on start with num_filters!=0.
- IDLE->FIN on start with num_filters==0.
REQ-025 SHALL, in FETCH, assert mem_en for exactly one cycle at mem_addr=base_addr+filter_idx, then enter WAIT.
REQ-026 SHALL, in WAIT, capture mem_data into a holding register, then enter EMIT with row=0.
REQ-027 SHALL, in EMIT, present descriptors as follows:
- out_len = ptr[r+1]-ptr[r], modulo 2^PTR_W.
- out_start = acc + ptr[r], zero-extended to OFS_W, with wrap-around modulo 2^OFS_W.
REQ-028 SHALL transfer a descriptor only when out_valid and out_ready are both high; while out_ready is low, all out_* signals SHALL hold stable.
REQ-029 SHALL, when SKIP_EMPTY=1, skip zero-length rows without asserting out_valid; if all rows of a filter are empty, the filter emits nothing and processing advances.
REQ-030 SHALL, after the last row of a filter:
- set acc <= acc + ptr[NUM_ROWS];
- increment filter_idx;
- go to FETCH, or go to FIN if it was the last filter.
REQ-031 SHALL assert out_last on the final emitted descriptor of the job; with SKIP_EMPTY, this is the last non-skipped row.
REQ-032 SHALL, in FIN, pulse done for one cycle and return to IDLE; busy is high in every state except IDLE.
REQ-033 SHALL achieve latency start->first out_valid of 3 cycles (FETCH, WAIT, EMIT), and throughput of 1 descriptor/cycle within a filter plus 2 bubble cycles per filter.
REQ-034 SHALL reset acc to 0 at every accepted start.

Reset
REQ-035 SHALL, on rst high, immediately force the following, including mid-job:
- state IDLE;
- mem_en=0, out_valid=0, out_last=0, busy=0, done=0, err=0;
- acc=0, filter_idx=0, holding register=0.
REQ-036 SHALL, after a mid-job reset, emit no descriptors until a new start.

Configuration
REQ-037 SHALL, with macro ROWPTR_CHECK_EN defined, set err on capture if any ptr[i+1]<ptr[i] or ptr[0]!=0; err clears only on reset or start, and streaming is unaffected.
REQ-038 SHALL, without ROWPTR_CHECK_EN, tie err to 0 and synthesise no comparison logic.

Structure
REQ-039 SHALL place the FSM state enum and the field-extract helper (index i -> bit offset) in shared package sparse_cnn_pkg.
REQ-040 SHALL use one sub-module, rowptr_unpack: a combinational split of the word into ptr[0..NUM_ROWS] and len[0..NUM_ROWS-1].

Verification
REQ-041 SHALL verify: word 0x000104040506, job of 1 filter, out_ready=1 -> (start,len) = (0,1),(1,3),(4,0),(4,1),(5,1); out_last on row 4; done 1 cycle later.
REQ-042 SHALL verify: same word then 0x000000000203, job of 2 filters -> second-filter starts 6,6,6,6,8 with lens 0,0,0,2,1; 2 bubble cycles between filters.
REQ-043 SHALL verify: SKIP_EMPTY=1 on the REQ-042 job -> row 2 of filter 0 and rows 0-2 of filter 1 are absent; out_last is on filter 1 row 4.
REQ-044 SHALL verify: out_ready toggled 0/1 each cycle -> no descriptor is lost or duplicated, and outputs are stable while stalled.
REQ-045 SHALL verify: ROWPTR_CHECK_EN with word 0x000304020506 -> err=1 after capture and stays 1; next start clears it.
REQ-046 SHALL verify: rst asserted during EMIT of filter 0 row 2 -> out_valid=0 immediately, no further descriptors; num_filters=0 start -> done pulse with no mem_en.

Source files
------------

// File: rtl/sparse_cnn_pkg.sv
// Shared types and helpers for the sparse-CNN row-pointer datapath.
// The row-pointer checker in rowptr_streamer is enabled by defining ROWPTR_CHECK_EN.
package sparse_cnn_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StEmit,
        StFin
    } rps_state_e;

    // Bit offset of pointer field idx; ptr[0] sits in the most significant field.
    function automatic int unsigned ptr_ofs(input int unsigned idx, input int unsigned num_rows,
                                            input int unsigned ptr_w);
        return (num_rows - idx) * ptr_w;
    endfunction

endpackage

// File: rtl/rowptr_unpack.sv
// Combinational split of one pointer-memory word into cumulative pointers and row lengths.
module rowptr_unpack
    import sparse_cnn_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 5,
    parameter int unsigned PTR_W    = 8
) (
    input  logic [(NUM_ROWS+1)*PTR_W-1:0] word,
    output logic [PTR_W-1:0]              ptr [NUM_ROWS+1],
    output logic [PTR_W-1:0]              len [NUM_ROWS]
);

    for (genvar i = 0; i <= NUM_ROWS; i++) begin : g_ptr
        assign ptr[i] = word[ptr_ofs(i, NUM_ROWS, PTR_W) +: PTR_W];
    end

    // Lengths wrap modulo 2^PTR_W so corrupt words still stream deterministically.
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_len
        assign len[i] = ptr[i+1] - ptr[i];
    end

endmodule

// File: rtl/rowptr_streamer.sv
// Streams per-row nonzero descriptors (start, len) from a CSR-style row-pointer memory.
// Define ROWPTR_CHECK_EN to enable the sticky pointer-corruption flag on err.
module rowptr_streamer
    import sparse_cnn_pkg::*;
#(
    parameter int unsigned NUM_ROWS   = 5,
    parameter int unsigned PTR_W      = 8,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned OFS_W      = 16,
    parameter int unsigned SKIP_EMPTY = 0,
    localparam int unsigned ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned WORD_W    = (NUM_ROWS + 1) * PTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_filters,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_filter,
    output logic [ROW_W-1:0]  out_row,
    output logic [OFS_W-1:0]  out_start,
    output logic [PTR_W-1:0]  out_len,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    rps_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, nf_q, nf_d, fidx_q, fidx_d;
    logic [OFS_W-1:0]  acc_q, acc_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [WORD_W-1:0] hold_q, hold_d;

    logic [PTR_W-1:0]  ptr [NUM_ROWS+1];
    logic [PTR_W-1:0]  len [NUM_ROWS];
    logic [PTR_W-1:0]  cur_len;
    logic              skip_row, last_row, last_filt, rest_empty;

    rowptr_unpack #(
        .NUM_ROWS (NUM_ROWS),
        .PTR_W    (PTR_W)
    ) u_unpack (
        .word (hold_q),
        .ptr  (ptr),
        .len  (len)
    );

    assign cur_len   = len[row_q];
    assign skip_row  = (SKIP_EMPTY != 0) && (cur_len == '0);
    assign last_row  = (row_q == ROW_W'(NUM_ROWS - 1));
    assign last_filt = (fidx_q == nf_q - ADDR_W'(1));

    // Only rows after the current one matter for deciding the final non-skipped row.
    always_comb begin
        rest_empty = 1'b1;
        for (int j = 0; j < NUM_ROWS; j++) begin
            if (j > int'(row_q) && len[j] != '0) rest_empty = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            nf_q    <= '0;
            fidx_q  <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nf_q    <= nf_d;
            fidx_q  <= fidx_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        nf_d      = nf_q;
        fidx_d    = fidx_q;
        acc_d     = acc_q;
        row_d     = row_q;
        hold_d    = hold_q;
        mem_en    = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    nf_d    = num_filters;
                    fidx_d  = '0;
                    acc_d   = '0;
                    state_d = (num_filters != '0) ? StFetch : StFin;
                end
            end
            StFetch: begin
                mem_en  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                hold_d  = mem_data;
                row_d   = '0;
                state_d = StEmit;
            end
            StEmit: begin
                out_valid = !skip_row;
                if (skip_row || out_ready) begin
                    if (last_row) begin
                        acc_d   = acc_q + OFS_W'(ptr[NUM_ROWS]);
                        fidx_d  = fidx_q + ADDR_W'(1);
                        state_d = last_filt ? StFin : StFetch;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_addr   = base_q + fidx_q;
    assign out_filter = fidx_q;
    assign out_row    = row_q;
    assign out_len    = cur_len;
    assign out_start  = acc_q + OFS_W'(ptr[row_q]);
    assign out_last   = out_valid && last_filt && ((SKIP_EMPTY != 0) ? rest_empty : last_row);
    assign busy       = (state_q != StIdle);

`ifdef ROWPTR_CHECK_EN
    logic err_q, bad_word;

    always_comb begin
        bad_word = (mem_data[ptr_ofs(0, NUM_ROWS, PTR_W) +: PTR_W] != '0);
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (mem_data[ptr_ofs(i + 1, NUM_ROWS, PTR_W) +: PTR_W] <
                mem_data[ptr_ofs(i, NUM_ROWS, PTR_W) +: PTR_W]) bad_word = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            err_q <= 1'b0;
        end else if (state_q == StWait && bad_word) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rowptr_streamer.sv
// Directed bench for rowptr_streamer: one DUT streams every row, a second one skips empty rows.
module tb_rowptr_streamer;

`ifdef ROWPTR_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    typedef struct {
        int f;
        int r;
        int st;
        int ln;
        int last;
        int cyc;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst, start, ready;
    logic [6:0]  base_addr, num_filters;
    logic [47:0] mem [128];

    logic        mem_en_a, valid_a, last_a, busy_a, done_a, err_a;
    logic [6:0]  mem_addr_a, filter_a;
    logic [47:0] rdata_a;
    logic [2:0]  row_a;
    logic [15:0] st_a;
    logic [7:0]  len_a;

    logic        mem_en_b, valid_b, last_b, busy_b, done_b, err_b;
    logic [6:0]  mem_addr_b, filter_b;
    logic [47:0] rdata_b;
    logic [2:0]  row_b;
    logic [15:0] st_b;
    logic [7:0]  len_b;

    // Hand-computed descriptors for words 0x000104040506 then 0x000000000203.
    int exp_st [10] = '{0, 1, 4, 4, 5, 6, 6, 6, 6, 8};
    int exp_ln [10] = '{1, 3, 0, 1, 1, 0, 0, 0, 2, 1};

    desc_t qa[$], qb[$];
    int cyc, n_checks, n_errors;
    int done_cnt_a, done_cnt_b, done_cyc_a, memen_cnt_a, stall_seen, stall_bad;
    int start_cyc, da0, db0;
    logic        prev_stall;
    logic [34:0] prev_snap;
    wire  [34:0] snap_a = {filter_a, row_a, st_a, len_a, last_a};

    always #5 clk = ~clk;

    rowptr_streamer #(.SKIP_EMPTY(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_filters(num_filters),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_data(rdata_a),
        .out_valid(valid_a), .out_ready(ready), .out_filter(filter_a), .out_row(row_a),
        .out_start(st_a), .out_len(len_a), .out_last(last_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    rowptr_streamer #(.SKIP_EMPTY(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_filters(num_filters),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_data(rdata_b),
        .out_valid(valid_b), .out_ready(ready), .out_filter(filter_b), .out_row(row_b),
        .out_start(st_b), .out_len(len_b), .out_last(last_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en_a) rdata_a <= mem[mem_addr_a];
        if (mem_en_b) rdata_b <= mem[mem_addr_b];
    end

    always @(negedge clk) begin
        if (valid_a && ready)
            qa.push_back('{int'(filter_a), int'(row_a), int'(st_a), int'(len_a), int'(last_a), cyc});
        if (valid_b && ready)
            qb.push_back('{int'(filter_b), int'(row_b), int'(st_b), int'(len_b), int'(last_b), cyc});
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            done_cyc_a <= cyc;
        end
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (mem_en_a) memen_cnt_a <= memen_cnt_a + 1;
        if (prev_stall && !rst) begin
            stall_seen <= stall_seen + 1;
            if (snap_a != prev_snap || !valid_a) stall_bad <= stall_bad + 1;
        end
        prev_stall <= valid_a && !ready && !rst;
        prev_snap  <= snap_a;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [6:0] base, input logic [6:0] nf);
        da0 = done_cnt_a;
        db0 = done_cnt_b;
        @(posedge clk); #1;
        base_addr   = base;
        num_filters = nf;
        start       = 1'b1;
        start_cyc   = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        for (int k = 0; k < 400; k++) begin
            if (done_cnt_a != da0 && done_cnt_b != db0) break;
            @(posedge clk); #1;
            if (toggle) ready = ~ready;
        end
        check("job_finished", int'(done_cnt_a != da0 && done_cnt_b != db0), 1);
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("done_one_cycle", done_cnt_a - da0, 1);
    endtask

    // mask bit e selects entry e of the two-filter table (filter e/5, row e%5).
    task automatic compare_job(input string tag, input bit use_b, input logic [9:0] mask,
                               input int last_i);
        desc_t q[$];
        int    idx[$];
        if (use_b) q = qb;
        else       q = qa;
        for (int e = 0; e < 10; e++) if (mask[e]) idx.push_back(e);
        check({tag, "_count"}, q.size(), idx.size());
        for (int k = 0; k < q.size() && k < idx.size(); k++) begin
            check({tag, "_filter"}, q[k].f,    idx[k] / 5);
            check({tag, "_row"},    q[k].r,    idx[k] % 5);
            check({tag, "_start"},  q[k].st,   exp_st[idx[k]]);
            check({tag, "_len"},    q[k].ln,   exp_ln[idx[k]]);
            check({tag, "_last"},   q[k].last, int'(idx[k] == last_i));
        end
    endtask

    initial begin
        bit found;
        int sz, mc, dc;
        rst = 1'b1; start = 1'b0; ready = 1'b1; base_addr = '0; num_filters = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[10] = 48'h000104040506;
        mem[20] = 48'h000104040506;
        mem[21] = 48'h000000000203;
        mem[30] = 48'h000304020506;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(valid_a), 0);
        check("rst_busy",  int'(busy_a),  0);
        check("rst_done",  int'(done_a),  0);
        check("rst_mem_en", int'(mem_en_a), 0);
        check("rst_err",   int'(err_a),   0);
        rst = 1'b0;

        // Single filter, always ready.
        qa.delete(); qb.delete();
        launch(7'd10, 7'd1);
        wait_done(1'b0);
        compare_job("one_a", 1'b0, 10'b0000011111, 4);
        compare_job("one_b", 1'b1, 10'b0000011011, 4);
        if (qa.size() == 5) begin
            check("latency", qa[0].cyc - start_cyc, 3);
            check("done_after_last", done_cyc_a - qa[4].cyc, 1);
        end else begin
            check("one_a_size_for_timing", qa.size(), 5);
        end

        // Two filters, always ready.
        qa.delete(); qb.delete();
        launch(7'd20, 7'd2);
        wait_done(1'b0);
        compare_job("two_a", 1'b0, 10'h3FF, 9);
        compare_job("two_b", 1'b1, 10'b1100011011, 9);
        if (qa.size() == 10) check("filter_gap", qa[5].cyc - qa[4].cyc, 3);
        else                 check("two_a_size_for_gap", qa.size(), 10);

        // Two filters with out_ready toggling every cycle.
        qa.delete(); qb.delete();
        launch(7'd20, 7'd2);
        wait_done(1'b1);
        compare_job("stall_a", 1'b0, 10'h3FF, 9);
        compare_job("stall_b", 1'b1, 10'b1100011011, 9);
        check("stall_observed", int'(stall_seen > 0), 1);
        check("stall_stable", stall_bad, 0);

        // Corrupt word: err behaviour, streaming unaffected, wrapped length.
        qa.delete(); qb.delete();
        launch(7'd30, 7'd1);
        wait_done(1'b0);
        check("err_set", int'(err_a), EXP_ERR);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", int'(err_a), EXP_ERR);
        check("bad_count", qa.size(), 5);
        if (qa.size() == 5) begin
            check("bad_len_wrap", qa[2].ln, 254);
            check("bad_start3", qa[3].st, 2);
        end
        launch(7'd10, 7'd1);
        check("err_cleared", int'(err_a), 0);
        wait_done(1'b0);

        // Reset while filter 0 row 2 is on the output.
        qa.delete(); qb.delete();
        launch(7'd20, 7'd2);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (valid_a && filter_a == 7'd0 && row_a == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("row2_reached", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid",  int'(valid_a),  0);
        check("midrst_busy",   int'(busy_a),   0);
        check("midrst_mem_en", int'(mem_en_a), 0);
        check("midrst_last",   int'(last_a),   0);
        sz = qa.size();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_more", qa.size(), sz);
        check("midrst_idle", int'(busy_a), 0);

        // Empty job: done pulse, no memory access.
        qa.delete(); qb.delete();
        mc = memen_cnt_a;
        dc = done_cnt_a;
        launch(7'd5, 7'd0);
        wait_done(1'b0);
        check("empty_mem_en", memen_cnt_a - mc, 0);
        check("empty_done", done_cnt_a - dc, 1);
        check("empty_desc", qa.size(), 0);
        check("empty_done_cyc", done_cyc_a - start_cyc, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
